// File: rtl/commit_wide.sv
// Multi-slot in-order commit stage: retires up to COMMIT_WIDTH ROB entries per cycle
// and serialises stores and branch mispredict flushes. Optional counters: COMMIT_PERF_CNT_EN.
module commit_wide #(
  parameter int COMMIT_WIDTH = 2,
  parameter int ROB_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [COMMIT_WIDTH-1:0]             slot_ready,
  input  logic [2*COMMIT_WIDTH-1:0]           slot_type,
  input  logic [32*COMMIT_WIDTH-1:0]          slot_value,
  input  logic [32*COMMIT_WIDTH-1:0]          slot_dest,
  input  logic [ROB_IDX_W*COMMIT_WIDTH-1:0]   slot_rob,
  input  logic [COMMIT_WIDTH-1:0]             slot_pred,
  input  logic [COMMIT_WIDTH-1:0]             slot_result,
  input  logic                                store_done,
  output logic [COMMIT_WIDTH-1:0]             reg_we,
  output logic [5*COMMIT_WIDTH-1:0]           reg_rd,
  output logic [32*COMMIT_WIDTH-1:0]          reg_wdata,
  output logic [ROB_IDX_W*COMMIT_WIDTH-1:0]   commit_rob,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]   rob_deq_cnt,
  output logic                                store_req,
  output logic                                bp_valid,
  output logic [31:0]                         bp_pc,
  output logic [31:0]                         bp_imm,
  output logic                                bp_pred,
  output logic                                bp_taken,
  output logic                                flush,
  output logic [31:0]                         redirect_pc,
  output logic [31:0]                         retired_cnt,
  output logic [31:0]                         mispred_cnt,
  output logic [1:0]                          dbg_state
);

  localparam int CNT_W  = $clog2(COMMIT_WIDTH + 1);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN = 2'd0, STORE_WAIT = 2'd1, FLUSH = 2'd2} state_t;

  state_t            state_q;
  logic              flush_q;
  logic [31:0]       redirect_pc_q;
  logic [FCNT_W-1:0] flush_cnt_q;
  logic              mispred;
  logic              store_enter;
  logic              stop;

  // Handshake: store_req is held high from the store reaching slot 0 until the cycle
  // store_done is sampled high in STORE_WAIT; that cycle retires the store.
  always_comb begin
    reg_we      = '0;
    reg_rd      = '0;
    reg_wdata   = '0;
    commit_rob  = '0;
    rob_deq_cnt = '0;
    store_req   = 1'b0;
    bp_valid    = 1'b0;
    bp_pc       = '0;
    bp_imm      = '0;
    bp_pred     = 1'b0;
    bp_taken    = 1'b0;
    mispred     = 1'b0;
    store_enter = 1'b0;
    stop        = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!stop) begin
              if (!slot_ready[i]) begin
                stop = 1'b1;
              end else if (slot_type[2*i +: 2] == 2'b00) begin
                // A branch ends the retire group so at most one updates the predictor.
                commit_rob[i*ROB_IDX_W +: ROB_IDX_W] = slot_rob[i*ROB_IDX_W +: ROB_IDX_W];
                rob_deq_cnt = CNT_W'(i + 1);
                bp_valid    = 1'b1;
                bp_pc       = slot_dest[i*32 +: 32];
                bp_imm      = slot_value[i*32 +: 32];
                bp_pred     = slot_pred[i];
                bp_taken    = slot_result[i];
                mispred     = slot_pred[i] != slot_result[i];
                stop        = 1'b1;
              end else if (slot_type[2*i +: 2] == 2'b01) begin
                if (i == 0) begin
                  store_req   = 1'b1;
                  store_enter = 1'b1;
                end
                stop = 1'b1;
              end else begin
                commit_rob[i*ROB_IDX_W +: ROB_IDX_W] = slot_rob[i*ROB_IDX_W +: ROB_IDX_W];
                rob_deq_cnt        = CNT_W'(i + 1);
                reg_we[i]          = |slot_dest[i*32 +: 5];
                reg_rd[i*5 +: 5]   = slot_dest[i*32 +: 5];
                reg_wdata[i*32 +: 32] = slot_value[i*32 +: 32];
              end
            end
          end
        end
        STORE_WAIT: begin
          store_req = 1'b1;
          if (store_done) begin
            commit_rob[ROB_IDX_W-1:0] = slot_rob[ROB_IDX_W-1:0];
            rob_deq_cnt = CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mispred) begin
            state_q       <= FLUSH;
            flush_q       <= 1'b1;
            redirect_pc_q <= bp_taken ? (bp_pc + bp_imm) : (bp_pc + 32'd4);
            flush_cnt_q   <= FCNT_W'(FLUSH_CYCLES - 1);
          end else if (store_enter) begin
            state_q <= STORE_WAIT;
          end
        end
        STORE_WAIT: if (store_done) state_q <= RUN;
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign dbg_state   = state_q;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] mispred_q, mispred_d;

  assign retired_d = retired_q + 32'(rob_deq_cnt);
  assign mispred_d = mispred_q + {31'd0, mispred};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      mispred_q <= '0;
    end else begin
      retired_q <= retired_d;
      mispred_q <= mispred_d;
    end
  end

  assign retired_cnt = retired_q;
  assign mispred_cnt = mispred_q;
`else
  assign retired_cnt = '0;
  assign mispred_cnt = '0;
`endif

endmodule
